// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA object path.
package vga_pkg;

    typedef enum logic [1:0] {IDLE, SINK, RESPAWN, HOLDOFF} pocket_state_t;

    localparam int OV_W  = 10;
    localparam int CNT_W = 4;
    localparam int FRM_W = 6;

    localparam logic [1:0] POCKET_NONE  = 2'd0;
    localparam logic [1:0] POCKET_HOLE1 = 2'd1;
    localparam logic [1:0] POCKET_HOLE2 = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pocket_sequencer_overlap_counter.sv
// overlap_counter: saturating per-frame pixel counter with a registered threshold flag.
module overlap_counter
    import vga_pkg::*;
#(
    parameter int TH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            clear,
    output logic [OV_W-1:0] count,
    output logic            ge
);

    localparam logic [OV_W-1:0] TH_V = OV_W'(TH);

    logic [OV_W-1:0] nxt;

    // clear wins over inc, so a pixel coincident with the clear is dropped
    always_comb nxt = clear ? '0 : (inc && !(&count)) ? count + 1'b1 : count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ge    <= 1'b0;
        end else begin
            count <= nxt;
            ge    <= nxt >= TH_V;
        end
    end

endmodule

// File: rtl/pocket_sequencer.sv
// pocket_sequencer: detects ball/hole overlap per frame and sequences the sink/respawn animation.
module pocket_sequencer
    import vga_pkg::*;
#(
    parameter int TH_PIXELS      = 16,
    parameter int SINK_FRAMES    = 30,
    parameter int HOLDOFF_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic             WBallDrawingRequest,
    input  logic             Hole_1_DrawingRequest,
    input  logic             Hole_2_DrawingRequest,
    output logic             ball_hide,
    output logic [FRM_W-1:0] sink_frame,
    output logic             pocketed_pulse,
    output logic [1:0]       pocket_id,
    output logic             respawn_pulse,
    output logic [CNT_W-1:0] hole1_count,
    output logic [CNT_W-1:0] hole2_count
);

    localparam logic [FRM_W-1:0] SINK_LAST = FRM_W'(SINK_FRAMES - 1);
    localparam logic [FRM_W-1:0] HOLD_LAST = FRM_W'(HOLDOFF_FRAMES - 1);

    pocket_state_t   state;
    logic [FRM_W-1:0] frame_cnt;
    logic [OV_W-1:0] ov1, ov2;
    logic            ge1, ge2;
    logic [1:0]      winner;

    overlap_counter #(.TH(TH_PIXELS)) u_ov1 (
        .clk   (clk),
        .reset (reset),
        .inc   (WBallDrawingRequest & Hole_1_DrawingRequest),
        .clear (startOfFrame),
        .count (ov1),
        .ge    (ge1)
    );

    overlap_counter #(.TH(TH_PIXELS)) u_ov2 (
        .clk   (clk),
        .reset (reset),
        .inc   (WBallDrawingRequest & Hole_2_DrawingRequest),
        .clear (startOfFrame),
        .count (ov2),
        .ge    (ge2)
    );

    // ties go to hole 2, matching the display mux precedence
    always_comb winner = (ov1 > ov2) ? POCKET_HOLE1 : POCKET_HOLE2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            frame_cnt      <= '0;
            ball_hide      <= 1'b0;
            sink_frame     <= '0;
            pocketed_pulse <= 1'b0;
            pocket_id      <= POCKET_NONE;
            respawn_pulse  <= 1'b0;
            hole1_count    <= '0;
            hole2_count    <= '0;
        end else begin
            pocketed_pulse <= 1'b0;
            respawn_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (startOfFrame && (ge1 || ge2)) begin
                        state          <= SINK;
                        frame_cnt      <= '0;
                        sink_frame     <= '0;
                        ball_hide      <= 1'b1;
                        pocketed_pulse <= 1'b1;
                        pocket_id      <= winner;
                        if (winner == POCKET_HOLE1) hole1_count <= sat_inc(hole1_count);
                        else hole2_count <= sat_inc(hole2_count);
                    end
                end
                SINK: begin
                    if (startOfFrame) begin
                        if (frame_cnt == SINK_LAST) begin
                            state         <= RESPAWN;
                            frame_cnt     <= '0;
                            sink_frame    <= '0;
                            ball_hide     <= 1'b0;
                            respawn_pulse <= 1'b1;
                        end else begin
                            frame_cnt  <= frame_cnt + 1'b1;
                            sink_frame <= frame_cnt + 1'b1;
                        end
                    end
                end
                RESPAWN: state <= HOLDOFF;
                HOLDOFF: begin
                    if (startOfFrame) begin
                        state     <= (frame_cnt == HOLD_LAST) ? IDLE : HOLDOFF;
                        frame_cnt <= (frame_cnt == HOLD_LAST) ? '0 : frame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
